// File: rtl/pp_pipeline_accel_fifo_pkg.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_fifo_pkg
// Shared helpers for the parametrised pp_pipeline_accel stream FIFO.
//   clog2            : ceiling log2 for sizing pointers and counters
//   addr_width       : pointer width, never narrower than one bit
//   thresholds_legal : elaboration-time sanity check of DEPTH/AF/AE
// ---------------------------------------------------------------------------
package pp_pipeline_accel_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int addr_width(input int depth);
    int width;
    width = clog2(depth);
    return (width < 1) ? 1 : width;
  endfunction

  function automatic bit thresholds_legal(input int depth, input int af_thresh, input int ae_thresh);
    return (depth >= 2) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_param_ram.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_fifo_param_ram
// DEPTH x DATA_WIDTH storage for the stream FIFO. Kept apart from the
// control logic so the storage maps cleanly onto LUTRAM or registers.
//   clk   : write clock
//   we    : write enable (synchronous)
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// ---------------------------------------------------------------------------
module pp_pipeline_accel_fifo_param_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pp_pipeline_accel_fifo_param.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_fifo_param
// First-word-fall-through stream FIFO with arbitrary DEPTH, implemented as a
// circular buffer. Provides almost-full/almost-empty thresholds, a
// synchronous flush and sticky overflow/underflow flags.
//   clk, reset          : clock, asynchronous active-high reset
//   if_din/if_write/_ce : write side; if_full_n = space available
//   if_read/_ce         : read side; if_dout valid while if_empty_n = 1
//   if_num_data_valid   : current occupancy
//   if_fifo_cap         : constant DEPTH
//   if_almost_full/empty: occupancy >= AF_THRESH / <= AE_THRESH
//   flush               : synchronous clear of contents and error flags
//   err_overflow/_underflow : sticky request-while-full/empty indicators
// ---------------------------------------------------------------------------
module pp_pipeline_accel_fifo_param
  import pp_pipeline_accel_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int ADDR_WIDTH = addr_width(DEPTH),
  localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_WIDTH-1:0]  if_num_data_valid,
  output logic [CNT_WIDTH-1:0]  if_fifo_cap,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  input  logic                  flush,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  if (!thresholds_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("pp_pipeline_accel_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  AF_CNT    = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0]  AE_CNT    = CNT_WIDTH'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  next_count;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;
  logic                  rd_acc;

  // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
  endfunction

  // Acceptance looks only at the registered flags, so a full FIFO rejects a
  // write even when a read drains it in the same cycle (and vice versa), and
  // no combinational path exists from the requests to the flags.
  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read & if_read_ce;
  assign wr_acc = wr_req & if_full_n & ~flush;
  assign rd_acc = rd_req & if_empty_n & ~flush;

  // Occupancy for the next cycle; flags are registered from this value.
  always_comb begin
    next_count = count;
    if (flush) begin
      next_count = '0;
    end else if (wr_acc && !rd_acc) begin
      next_count = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      next_count = count - 1'b1;
    end
  end

  // Pointer, occupancy, flag and sticky error state. Flush wins over any
  // read or write issued in the same cycle and clears the error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      if_empty_n      <= 1'b0;
      if_full_n       <= 1'b1;
      if_almost_full  <= 1'b0;
      if_almost_empty <= 1'b1;
      err_overflow    <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= advance(wr_ptr);
        end
        if (rd_acc) begin
          rd_ptr <= advance(rd_ptr);
        end
      end
      count           <= next_count;
      if_empty_n      <= (next_count != '0);
      if_full_n       <= (next_count != DEPTH_CNT);
      if_almost_full  <= (next_count >= AF_CNT);
      if_almost_empty <= (next_count <= AE_CNT);
      if (flush) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end else begin
        if (wr_req && !if_full_n) begin
          err_overflow <= 1'b1;
        end
        if (rd_req && !if_empty_n) begin
          err_underflow <= 1'b1;
        end
      end
    end
  end

  pp_pipeline_accel_fifo_param_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (if_din),
    .raddr (rd_ptr),
    .rdata (if_dout)
  );

  assign if_num_data_valid = count;
  assign if_fifo_cap       = DEPTH_CNT;

endmodule
